// File: rtl/tcp_sched_pkg.sv
// Shared types and helpers for the TCP read-package scheduler.
package tcp_sched_pkg;

  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] session;
  } rdpkg_req_t;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ISSUE} sched_state_e;

  // Beats needed for a payload; 10-bit result, lengths above 65472 wrap.
  function automatic logic [9:0] beats_of(input logic [15:0] length);
    return length[15:BEAT_SHIFT] + {9'd0, |length[BEAT_SHIFT-1:0]};
  endfunction

endpackage

// File: rtl/rdpkg_notif_fifo.sv
// First-word-fall-through FIFO for queued RX notifications.
module rdpkg_notif_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [AW:0]               wr_ptr, rd_ptr;
  logic [DEPTH-1:0][W-1:0]   mem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Extra pointer bit distinguishes full from empty when indices match.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tcp_rdpkg_scheduler.sv
// Credit-based scheduler: queued RX notifications -> read-package requests.
// Optional stall watchdog enabled by defining TCP_RDPKG_TIMEOUT_EN.
module tcp_rdpkg_scheduler
  import tcp_sched_pkg::*;
#(
  parameter int NOTIF_DEPTH = 16,
  parameter int BUF_BEATS   = 1024,
  parameter int CNT_W       = 12
`ifdef TCP_RDPKG_TIMEOUT_EN
  , parameter logic [31:0] STALL_CYCLES = 32'd250000000
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_notif_valid,
  output logic             s_notif_ready,
  input  logic [87:0]      s_notif_data,
  output logic             m_rdpkg_valid,
  input  logic             m_rdpkg_ready,
  output logic [31:0]      m_rdpkg_data,
  input  logic             rx_beat_pop,
  input  logic             cfg_enable,
  output logic [CNT_W-1:0] stat_outstanding,
  output logic [31:0]      stat_drop_cnt,
  output logic             stat_underflow
`ifdef TCP_RDPKG_TIMEOUT_EN
  , output logic           stat_stall
`endif
);

  localparam int QAW = $clog2(NOTIF_DEPTH);

  sched_state_e      state, state_nx;
  logic              rdy_en;
  logic              q_pop, q_full, q_empty;
  logic [QAW:0]      q_count;
  rdpkg_req_t        head;
  logic [CNT_W-1:0]  outstanding, out_sum, out_nx, need_r, need_c;
  logic [CNT_W:0]    room_sum;
  logic              hs, fits, load, drop, uflow_set;
  logic              unused_notif;

  assign unused_notif = ^s_notif_data[87:32];

  // Ready held low through reset and until the first clock after release.
  assign s_notif_ready = rdy_en & ~q_full;

  rdpkg_notif_fifo #(.DEPTH(NOTIF_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (s_notif_valid & s_notif_ready),
    .pop   (q_pop),
    .din   (s_notif_data[31:0]),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign need_c   = {{(CNT_W-10){1'b0}}, beats_of(head.length)};
  assign room_sum = {1'b0, outstanding} + {1'b0, need_c};
  // An oversized request is allowed through alone once the buffer is empty.
  assign fits     = (room_sum <= (CNT_W+1)'(BUF_BEATS)) || (outstanding == '0);

  assign m_rdpkg_valid = (state == S_ISSUE);
  assign hs            = m_rdpkg_valid & m_rdpkg_ready;

  always_comb begin
    state_nx = state;
    q_pop    = 1'b0;
    load     = 1'b0;
    drop     = 1'b0;
    case (state)
      S_IDLE:  if (!q_empty && cfg_enable) state_nx = S_EVAL;
      S_EVAL: begin
        if (!cfg_enable || q_count == '0) begin
          state_nx = S_IDLE;
        end else if (head.length == '0) begin
          q_pop    = 1'b1;
          drop     = 1'b1;
          state_nx = S_IDLE;
        end else if (fits) begin
          q_pop    = 1'b1;
          load     = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: if (m_rdpkg_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    out_sum   = outstanding + (hs ? need_r : '0);
    out_nx    = out_sum;
    uflow_set = 1'b0;
    if (rx_beat_pop) begin
      if (out_sum == '0) uflow_set = 1'b1;
      else               out_nx    = out_sum - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      rdy_en         <= 1'b0;
      m_rdpkg_data   <= '0;
      need_r         <= '0;
      stat_drop_cnt  <= '0;
      stat_underflow <= 1'b0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      if (load) begin
        m_rdpkg_data <= head;
        need_r       <= need_c;
      end
      if (drop)      stat_drop_cnt  <= stat_drop_cnt + 32'd1;
      if (uflow_set) stat_underflow <= 1'b1;
    end
  end

`ifdef TCP_RDPKG_TIMEOUT_EN
  logic [31:0] stall_cnt;
  logic        stalling, stall_hit;

  assign stalling  = (state == S_EVAL) && cfg_enable && (q_count != '0) &&
                     (head.length != '0) && !fits;
  assign stall_hit = stalling && (stall_cnt == STALL_CYCLES - 32'd1);

  // Long credit stall means pop pulses were lost; forget the outstanding count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt   <= '0;
      stat_stall  <= 1'b0;
      outstanding <= '0;
    end else begin
      stall_cnt   <= (stalling && !stall_hit) ? stall_cnt + 32'd1 : '0;
      if (stall_hit) stat_stall <= 1'b1;
      outstanding <= stall_hit ? '0 : out_nx;
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) outstanding <= '0;
    else       outstanding <= out_nx;
  end
`endif

  assign stat_outstanding = outstanding;

endmodule
